// File: rtl/led_divider_bank.sv
// Bank of independent LED / clock-enable dividers with shadowed config.
// Each channel runs TOGGLE, PULSE or PWM from a synchronised enable.
module led_divider_bank #(
  parameter int CHANNELS    = 4,
  parameter int WIDTH       = 32,
  parameter int DEFAULT_DIV = 2**27-1,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] en,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [3:0]          cfg_ch,
  input  logic [1:0]          cfg_mode,
  input  logic [WIDTH-1:0]    cfg_div,
  input  logic [WIDTH-1:0]    cfg_duty,
  output logic                cfg_err,
  output logic [CHANNELS-1:0] out,
  output logic [CHANNELS-1:0] tick
);

  typedef enum logic [1:0] {
    M_TOGGLE = 2'd0,
    M_PULSE  = 2'd1,
    M_PWM    = 2'd2,
    M_OFF    = 2'd3
  } mode_e;

  localparam logic [WIDTH-1:0] DEF_DIV = WIDTH'(DEFAULT_DIV);

  logic [CHANNELS-1:0] r_sync [SYNC_STAGES];
  logic [CHANNELS-1:0] w_pend;
  logic                w_xfer;
  logic                w_bad;
  logic                r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        r_sync[s] <= '0;
      end
    end else begin
      r_sync[0] <= en;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        r_sync[s] <= r_sync[s-1];
      end
    end
  end

  assign cfg_ready = ~|w_pend;
  assign w_xfer    = cfg_valid & cfg_ready;
  assign w_bad     = int'(cfg_ch) >= CHANNELS;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else begin
      r_err <= w_xfer & w_bad;
    end
  end

  assign cfg_err = r_err;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_div;
    logic [WIDTH-1:0] r_duty;
    logic [WIDTH-1:0] r_sdiv;
    logic [WIDTH-1:0] r_sduty;
    mode_e            r_mode;
    mode_e            r_smode;
    logic             r_pend;
    logic             r_out;
    logic             r_tick;
    logic             w_en;
    logic             w_run;
    logic             w_tc;
    logic             w_sel;
    logic             w_apply;
    logic [WIDTH-1:0] w_cnt_nxt;
    logic             w_out_nxt;

    assign w_en  = r_sync[SYNC_STAGES-1][g];
    assign w_run = w_en && (r_mode != M_OFF);
    assign w_tc  = w_run && (r_cnt == r_div);
    assign w_sel = w_xfer && (cfg_ch == 4'(g));
    // Idle channels and moves into OFF take the shadow at once
    assign w_apply = r_pend &&
      (w_tc || !w_en || r_mode == M_OFF || r_smode == M_OFF);

    always_comb begin
      w_cnt_nxt = r_cnt;
      w_out_nxt = r_out;
      if (w_apply) begin
        w_cnt_nxt = '0;
        case (r_smode)
          M_TOGGLE: w_out_nxt = (r_mode == M_TOGGLE) ? (r_out ^ w_tc) : 1'b0;
          M_PULSE:  w_out_nxt = w_tc;
          M_PWM:    w_out_nxt = (r_sduty != '0);
          default:  w_out_nxt = 1'b0;
        endcase
      end else if (r_mode == M_OFF) begin
        w_cnt_nxt = '0;
        w_out_nxt = 1'b0;
      end else if (!w_en) begin
        if (r_mode == M_PULSE) begin
          w_out_nxt = 1'b0;
        end
      end else begin
        w_cnt_nxt = w_tc ? '0 : r_cnt + WIDTH'(1);
        case (r_mode)
          M_TOGGLE: w_out_nxt = r_out ^ w_tc;
          M_PULSE:  w_out_nxt = w_tc;
          M_PWM:    w_out_nxt = (w_cnt_nxt < r_duty);
          default:  w_out_nxt = 1'b0;
        endcase
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_cnt   <= '0;
        r_div   <= DEF_DIV;
        r_duty  <= '0;
        r_mode  <= M_TOGGLE;
        r_sdiv  <= DEF_DIV;
        r_sduty <= '0;
        r_smode <= M_TOGGLE;
        r_pend  <= 1'b0;
        r_out   <= 1'b0;
        r_tick  <= 1'b0;
      end else begin
        r_cnt  <= w_cnt_nxt;
        r_out  <= w_out_nxt;
        r_tick <= w_tc;
        if (w_apply) begin
          r_div  <= r_sdiv;
          r_duty <= r_sduty;
          r_mode <= r_smode;
          r_pend <= 1'b0;
        end
        if (w_sel) begin
          r_sdiv  <= cfg_div;
          r_sduty <= cfg_duty;
          r_smode <= mode_e'(cfg_mode);
          r_pend  <= 1'b1;
        end
      end
    end

    assign w_pend[g] = r_pend;
    assign out[g]    = r_out;
    assign tick[g]   = r_tick;
  end

endmodule

// File: tb/tb_led_divider_bank.sv
// Scoreboard bench for led_divider_bank: directed config scenarios,
// expectations queued by cycle number and checked by a monitor.
module tb_led_divider_bank;

  localparam int S_OUT   = 0;
  localparam int S_TICK  = 1;
  localparam int S_RDY   = 2;
  localparam int S_ERR   = 3;
  localparam int S_OUTV  = 4;
  localparam int S_TICKV = 5;

  typedef struct {
    int          cyc;
    int          sig;
    int          ch;
    logic [31:0] exp;
    string       name;
  } item_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] en = 4'hF;
  logic       cfg_valid = 1'b0;
  logic       cfg_ready;
  logic [3:0] cfg_ch = '0;
  logic [1:0] cfg_mode = '0;
  logic [7:0] cfg_div = '0;
  logic [7:0] cfg_duty = '0;
  logic       cfg_err;
  logic [3:0] out;
  logic [3:0] tick;

  int    cyc = 0;
  int    n_checks = 0;
  int    n_errors = 0;
  item_t sbq[$];

  led_divider_bank #(
    .CHANNELS(4), .WIDTH(8), .DEFAULT_DIV(7), .SYNC_STAGES(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch), .cfg_mode(cfg_mode),
    .cfg_div(cfg_div), .cfg_duty(cfg_duty),
    .cfg_err(cfg_err), .out(out), .tick(tick)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] sample(int sig, int ch);
    case (sig)
      S_OUT:   return {31'd0, out[ch]};
      S_TICK:  return {31'd0, tick[ch]};
      S_RDY:   return {31'd0, cfg_ready};
      S_ERR:   return {31'd0, cfg_err};
      S_OUTV:  return {28'd0, out};
      default: return {28'd0, tick};
    endcase
  endfunction

  always @(negedge clk) begin
    logic [31:0] act;
    for (int i = sbq.size() - 1; i >= 0; i--) begin
      if (sbq[i].cyc == cyc) begin
        act = sample(sbq[i].sig, sbq[i].ch);
        n_checks++;
        if (act !== sbq[i].exp) begin
          n_errors++;
          $display("FAIL %s cyc %0d got %0h want %0h",
                   sbq[i].name, cyc, act, sbq[i].exp);
        end
        sbq.delete(i);
      end else if (sbq[i].cyc < cyc) begin
        n_checks++;
        n_errors++;
        $display("FAIL %s missed cyc %0d got none want %0h",
                 sbq[i].name, sbq[i].cyc, sbq[i].exp);
        sbq.delete(i);
      end
    end
  end

  task automatic expect_at(int c, int sig, int ch, int v, string nm);
    item_t it;
    it.cyc  = c;
    it.sig  = sig;
    it.ch   = ch;
    it.exp  = 32'(v);
    it.name = nm;
    sbq.push_back(it);
  endtask

  task automatic at(int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic cfg(int n, int ch, int mode, int div, int duty);
    at(n);
    cfg_valid = 1'b1;
    cfg_ch    = 4'(ch);
    cfg_mode  = 2'(mode);
    cfg_div   = 8'(div);
    cfg_duty  = 8'(duty);
    at(n + 1);
    cfg_valid = 1'b0;
  endtask

  initial begin
    // reset state and default TOGGLE div 7 on all channels
    expect_at(1, S_OUTV, 0, 0, "rst_out");
    expect_at(1, S_TICKV, 0, 0, "rst_tick");
    expect_at(1, S_RDY, 0, 1, "rst_ready");
    expect_at(1, S_ERR, 0, 0, "rst_err");
    expect_at(11, S_TICKV, 0, 0, "def_tick11");
    expect_at(12, S_TICKV, 0, 15, "def_tick12");
    expect_at(12, S_OUTV, 0, 15, "def_out12");
    expect_at(13, S_TICKV, 0, 0, "def_tick13");
    expect_at(19, S_OUTV, 0, 15, "def_out19");
    expect_at(20, S_OUTV, 0, 0, "def_out20");
    expect_at(20, S_TICKV, 0, 15, "def_tick20");
    at(2);
    rst_n = 1'b1;

    // ch1 PWM div 9 duty 3, applied at ch1 terminal count 28
    expect_at(23, S_RDY, 0, 0, "pwm_rdy23");
    expect_at(27, S_RDY, 0, 0, "pwm_rdy27");
    expect_at(28, S_RDY, 0, 1, "pwm_rdy28");
    expect_at(27, S_OUT, 1, 0, "pwm_out27");
    expect_at(30, S_OUT, 1, 1, "pwm_out30");
    expect_at(31, S_OUT, 1, 0, "pwm_out31");
    expect_at(37, S_OUT, 1, 0, "pwm_out37");
    expect_at(37, S_TICK, 1, 0, "pwm_tick37");
    expect_at(38, S_OUT, 1, 1, "pwm_out38");
    expect_at(38, S_TICK, 1, 1, "pwm_tick38");
    expect_at(40, S_OUT, 1, 1, "pwm_out40");
    expect_at(41, S_OUT, 1, 0, "pwm_out41");
    expect_at(36, S_OUT, 0, 0, "ch0_out36");
    cfg(22, 1, 2, 9, 3);

    // ch2 PULSE div 0, then en[2] dropped
    expect_at(41, S_RDY, 0, 0, "pul_rdy41");
    expect_at(44, S_RDY, 0, 1, "pul_rdy44");
    expect_at(43, S_TICK, 2, 0, "pul_tick43");
    expect_at(45, S_OUT, 2, 1, "pul_out45");
    expect_at(45, S_TICK, 2, 1, "pul_tick45");
    expect_at(46, S_OUT, 2, 1, "pul_out46");
    expect_at(46, S_TICK, 2, 1, "pul_tick46");
    expect_at(52, S_TICK, 2, 1, "dis_tick52");
    expect_at(53, S_TICK, 2, 0, "dis_tick53");
    expect_at(53, S_OUT, 2, 0, "dis_out53");
    expect_at(56, S_OUT, 2, 0, "dis_out56");
    cfg(40, 2, 1, 0, 0);
    at(50);
    en = 4'b1011;

    // bad channel index
    expect_at(55, S_ERR, 0, 1, "err55");
    expect_at(56, S_ERR, 0, 0, "err56");
    expect_at(55, S_RDY, 0, 1, "err_rdy55");
    expect_at(59, S_OUT, 0, 0, "err_ch0_59");
    expect_at(60, S_OUT, 0, 1, "err_ch0_60");
    expect_at(58, S_OUT, 1, 1, "err_ch1_58");
    expect_at(58, S_TICK, 1, 1, "err_tick1_58");
    cfg(54, 9, 2, 1, 1);

    // ch3 PWM duty 0, duty div+1, OFF, then leave OFF as TOGGLE div 1
    expect_at(67, S_OUT, 3, 1, "d0_out67");
    expect_at(68, S_OUT, 3, 0, "d0_out68");
    expect_at(72, S_OUT, 3, 0, "d0_out72");
    expect_at(73, S_OUT, 3, 0, "d0_out73");
    expect_at(74, S_OUT, 3, 1, "dfull_out74");
    expect_at(77, S_OUT, 3, 1, "dfull_out77");
    expect_at(80, S_OUT, 3, 1, "dfull_out80");
    expect_at(81, S_OUT, 3, 1, "off_out81");
    expect_at(82, S_OUT, 3, 0, "off_out82");
    expect_at(85, S_OUT, 3, 0, "off_out85");
    expect_at(85, S_TICK, 3, 0, "off_tick85");
    expect_at(88, S_OUT, 3, 0, "leave_out88");
    expect_at(88, S_TICK, 3, 0, "leave_tick88");
    expect_at(89, S_OUT, 3, 0, "leave_out89");
    expect_at(90, S_OUT, 3, 1, "leave_out90");
    expect_at(90, S_TICK, 3, 1, "leave_tick90");
    expect_at(91, S_TICK, 3, 0, "leave_tick91");
    expect_at(92, S_OUT, 3, 0, "leave_out92");
    cfg(62, 3, 2, 5, 0);
    cfg(68, 3, 2, 5, 6);
    cfg(80, 3, 3, 5, 6);
    cfg(86, 3, 0, 1, 0);

    // reset while ch0 config pending
    expect_at(96, S_RDY, 0, 0, "mid_rdy96");
    expect_at(97, S_RDY, 0, 1, "rst2_rdy97");
    expect_at(97, S_OUTV, 0, 0, "rst2_out97");
    expect_at(97, S_TICKV, 0, 0, "rst2_tick97");
    expect_at(100, S_RDY, 0, 1, "rst2_rdy100");
    expect_at(108, S_TICKV, 0, 0, "rst2_tick108");
    expect_at(109, S_TICKV, 0, 11, "rst2_tick109");
    expect_at(109, S_OUTV, 0, 11, "rst2_out109");
    cfg(94, 0, 2, 3, 1);
    at(97);
    rst_n = 1'b0;
    at(99);
    rst_n = 1'b1;

    at(115);
    @(negedge clk);
    if (sbq.size() != 0) begin
      $display("FAIL sb_drain left %0d want 0", sbq.size());
    end
    $display("CHECKS %0d ERRORS %0d", n_checks,
             n_errors + ((sbq.size() != 0) ? 1 : 0));
    $finish;
  end

endmodule
